prog_timer_mc: RTL and testbench

PROG_TIMER_MC -- requirements
Module: prog_timer_mc

---
 rtl/prog_timer_pkg.sv | 50 +++++
 rtl/timer_channel.sv | 126 ++++++++++++
 rtl/prog_timer_mc.sv | 56 +++++
 tb/tb_prog_timer_mc.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_timer_pkg.sv
// Shared definitions for the multi-channel programmable timer:
// mode encodings, channel state enum, write validation and waveform decode.
package prog_timer_pkg;

    localparam logic [2:0] MODE0     = 3'd0;
    localparam logic [2:0] MODE1     = 3'd1;
    localparam logic [2:0] MODE2     = 3'd2;
    localparam logic [2:0] MODE3     = 3'd3;
    localparam logic [2:0] MODE4     = 3'd4;
    localparam logic [2:0] MODE_STOP = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } ch_state_t;

    // Returns 1 when a program write may be accepted.
    function automatic logic valid_write(input int unsigned ch, input int unsigned num_ch,
                                         input logic [2:0] mode, input int unsigned n);
        logic ok;
        ok = 1'b1;
        if (ch >= num_ch)
            ok = 1'b0;
        if (mode == 3'd5 || mode == 3'd6)
            ok = 1'b0;
        if (mode <= MODE4 && n < 2)
            ok = 1'b0;
        if (mode == MODE2 && n[0])
            ok = 1'b0;
        if ((mode == MODE3 || mode == MODE4) && !n[0])
            ok = 1'b0;
        return ok;
    endfunction

    // Output level for count value c within a period of n; widened to
    // 32 bits so (n+1)/2 cannot overflow at n = 2^CNT_W-1.
    function automatic logic out_decode(input logic [2:0] mode, input int unsigned n,
                                        input int unsigned c);
        case (mode)
            MODE0:   return c == n - 1;
            MODE1:   return c != n - 1;
            MODE2:   return c >= n / 2;
            MODE3:   return c >= (n + 1) / 2;
            MODE4:   return c >= (n - 1) / 2;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: shadow config, IDLE/RUN/HOLD FSM, down-counter and
// registered waveform decode.
//
// state   | meaning
// IDLE    | stopped, out=0, waits for gate=1 with a pending config
// RUN     | counting down one step per gated cycle
// HOLD    | gate low; count and out frozen
module timer_channel
    import prog_timer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             stop,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] cnt,
    input  logic             gate,
    output logic             out,
    output logic             active,
    output logic             pending
);

    ch_state_t        state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [CNT_W-1:0] n_cur, n_nxt;
    logic [CNT_W-1:0] sh_n, sh_n_nxt;
    logic [2:0]       mode_cur, mode_nxt;
    logic [2:0]       sh_mode, sh_mode_nxt;
    logic             pending_nxt;
    logic             out_nxt;
    logic             take_shadow;
    logic             upd;

    // State, counter, shadow and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            count    <= '0;
            n_cur    <= '0;
            mode_cur <= MODE0;
            sh_n     <= '0;
            sh_mode  <= MODE0;
            pending  <= 1'b0;
            out      <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            n_cur    <= n_nxt;
            mode_cur <= mode_nxt;
            sh_n     <= sh_n_nxt;
            sh_mode  <= sh_mode_nxt;
            pending  <= pending_nxt;
            out      <= out_nxt;
        end
    end

    // Next-state, count step/reload and output decode of the loaded count.
    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        n_nxt       = n_cur;
        mode_nxt    = mode_cur;
        sh_n_nxt    = sh_n;
        sh_mode_nxt = sh_mode;
        pending_nxt = pending;
        out_nxt     = out;
        take_shadow = 1'b0;
        upd         = 1'b0;

        case (state)
            ST_IDLE: begin
                if (gate && pending) begin
                    state_nxt   = ST_RUN;
                    take_shadow = 1'b1;
                end
            end
            ST_RUN, ST_HOLD: begin
                if (!gate) begin
                    state_nxt = ST_HOLD;
                end else begin
                    // Resuming from HOLD counts on the same edge so no cycle is lost.
                    state_nxt = ST_RUN;
                    upd       = 1'b1;
                    if (count != '0)
                        count_nxt = count - 1'b1;
                    else if (pending)
                        take_shadow = 1'b1;
                    else
                        count_nxt = n_cur - 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Uses the registered shadow, so a write on this same edge waits
        // for the next terminal count.
        if (take_shadow) begin
            mode_nxt    = sh_mode;
            n_nxt       = sh_n;
            count_nxt   = sh_n - 1'b1;
            pending_nxt = 1'b0;
            upd         = 1'b1;
        end

        if (upd)
            out_nxt = out_decode(mode_nxt, 32'(n_nxt), 32'(count_nxt));

        if (load) begin
            sh_mode_nxt = mode;
            sh_n_nxt    = cnt;
            pending_nxt = 1'b1;
        end

        if (stop) begin
            state_nxt   = ST_IDLE;
            pending_nxt = 1'b0;
            count_nxt   = '0;
            out_nxt     = 1'b0;
        end
    end

    assign active = (state != ST_IDLE);

endmodule

// File: rtl/prog_timer_mc.sv
// Multi-channel programmable timer: write validation, per-channel write
// decode and the rejected-write error pulse; timing lives in timer_channel.
module prog_timer_mc
    import prog_timer_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = 8,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [2:0]        wr_mode,
    input  logic [CNT_W-1:0]  wr_cnt,
    input  logic [NUM_CH-1:0] gate,
    output logic [NUM_CH-1:0] out,
    output logic [NUM_CH-1:0] active,
    output logic [NUM_CH-1:0] pending,
    output logic              wr_err
);

    logic wr_ok;

    assign wr_ok = valid_write(32'(wr_ch), NUM_CH, wr_mode, 32'(wr_cnt));

    // One-cycle error pulse after a rejected write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wr_err <= 1'b0;
        else
            wr_err <= wr_en && !wr_ok;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;

        assign sel = wr_en && wr_ok && (32'(wr_ch) == i);

        timer_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .load   (sel && (wr_mode != MODE_STOP)),
            .stop   (sel && (wr_mode == MODE_STOP)),
            .mode   (wr_mode),
            .cnt    (wr_cnt),
            .gate   (gate[i]),
            .out    (out[i]),
            .active (active[i]),
            .pending(pending[i])
        );
    end

endmodule

// File: tb/tb_prog_timer_mc.sv
// Self-checking bench for prog_timer_mc: directed scenarios followed by
// random writes/gating, all compared against a period-position model.
module tb_prog_timer_mc;

    localparam int NCH = 3;
    localparam int CW  = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           wr_en = 1'b0;
    logic [1:0]     wr_ch = '0;
    logic [2:0]     wr_mode = '0;
    logic [CW-1:0]  wr_cnt = '0;
    logic [NCH-1:0] gate = '0;
    logic [NCH-1:0] out, active, pending;
    logic           wr_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    prog_timer_mc #(.NUM_CH(NCH), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode),
        .wr_cnt(wr_cnt), .gate(gate), .out(out), .active(active), .pending(pending),
        .wr_err(wr_err)
    );

    // Model: each channel is either stopped or somewhere in its period (pos).
    bit m_act[NCH];
    bit m_pend[NCH];
    int m_pos[NCH], m_mode[NCH], m_n[NCH], m_smode[NCH], m_sn[NCH];
    bit m_err;

    function automatic bit ref_ok(int ch, int mode, int n);
        if (ch >= NCH) return 1'b0;
        case (mode)
            0, 1:    return n >= 2;
            2:       return n >= 2 && (n % 2) == 0;
            3, 4:    return n >= 3 && (n % 2) == 1;
            7:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Level at position p of the period (p=0 is the cycle after load).
    function automatic bit wave(int mode, int n, int p);
        case (mode)
            0:       return p == 0;
            1:       return p != 0;
            2:       return p < n / 2;
            3:       return p < (n - 1) / 2;
            4:       return p < (n + 1) / 2;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_act[c] = 0; m_pend[c] = 0; m_pos[c] = 0; m_mode[c] = 0;
            m_n[c] = 0; m_smode[c] = 0; m_sn[c] = 0;
        end
        m_err = 0;
    endtask

    task automatic model_step();
        bit ok;
        ok = ref_ok(int'(wr_ch), int'(wr_mode), int'(wr_cnt));
        for (int c = 0; c < NCH; c++) begin
            if (m_act[c]) begin
                if (gate[c]) begin
                    m_pos[c]++;
                    if (m_pos[c] == m_n[c]) begin
                        m_pos[c] = 0;
                        if (m_pend[c]) begin
                            m_mode[c] = m_smode[c]; m_n[c] = m_sn[c]; m_pend[c] = 0;
                        end
                    end
                end
            end else if (gate[c] && m_pend[c]) begin
                m_act[c] = 1; m_pos[c] = 0;
                m_mode[c] = m_smode[c]; m_n[c] = m_sn[c]; m_pend[c] = 0;
            end
            if (wr_en && ok && int'(wr_ch) == c) begin
                if (wr_mode == 3'd7) begin
                    m_act[c] = 0; m_pend[c] = 0; m_pos[c] = 0;
                end else begin
                    m_smode[c] = int'(wr_mode); m_sn[c] = int'(wr_cnt); m_pend[c] = 1;
                end
            end
        end
        m_err = wr_en && !ok;
    endtask

    function automatic logic [NCH-1:0] exp_out();
        logic [NCH-1:0] v;
        v = '0;
        for (int c = 0; c < NCH; c++) v[c] = m_act[c] && wave(m_mode[c], m_n[c], m_pos[c]);
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_act();
        logic [NCH-1:0] v;
        v = '0;
        for (int c = 0; c < NCH; c++) v[c] = m_act[c];
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_pend();
        logic [NCH-1:0] v;
        v = '0;
        for (int c = 0; c < NCH; c++) v[c] = m_pend[c];
        return v;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("out", 32'(out), 32'(exp_out()));
        chk("active", 32'(active), 32'(exp_act()));
        chk("pending", 32'(pending), 32'(exp_pend()));
        chk("wr_err", 32'(wr_err), 32'(m_err));
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        check_all();
    endtask

    task automatic run(int k);
        repeat (k) step();
    endtask

    task automatic write(int ch, int mode, int n);
        wr_en = 1'b1; wr_ch = 2'(ch); wr_mode = 3'(mode); wr_cnt = CW'(n);
        step();
        wr_en = 1'b0;
    endtask

    task automatic async_reset();
        #3 rst_n = 1'b0;
        #1;
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        model_reset();
        run(2);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [6:0] w_m2;
        logic [4:0] w_m3;
        logic       held;
        w_m2 = 7'b1000111;
        w_m3 = 5'b00011;
        model_reset();

        // Reset state
        run(2);
        rst_n = 1'b1;
        run(1);

        // Mode 2, n=6 on ch0: three high, three low, first high after load
        gate = 3'b001;
        write(0, 2, 6);
        chk("m2_pending", 32'(pending[0]), 32'd1);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("m2_wave", 32'(out[0]), 32'(w_m2[i]));
        end

        // Mode 3 then mode 4, n=5 on ch1
        gate = 3'b011;
        write(1, 3, 5);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("m3_wave", 32'(out[1]), 32'(w_m3[i]));
        end
        write(1, 4, 5);
        run(12);

        // Rejected writes: single error pulse each, no state change
        write(1, 2, 7);
        chk("err_m2_odd", 32'(wr_err), 32'd1);
        run(1);
        write(1, 3, 4);
        chk("err_m3_even", 32'(wr_err), 32'd1);
        run(1);
        write(1, 6, 5);
        chk("err_reserved", 32'(wr_err), 32'd1);
        run(1);
        write(3, 0, 4);
        chk("err_bad_ch", 32'(wr_err), 32'd1);
        run(1);
        chk("err_cleared", 32'(wr_err), 32'd0);

        // Mode 0 n=4 on ch2, rewritten to n=8 mid-period
        gate = 3'b111;
        write(2, 0, 4);
        run(2);
        write(2, 0, 8);
        chk("m0_pending", 32'(pending[2]), 32'd1);
        run(20);

        // Gate ch0 low for 5 cycles mid-period
        run(2);
        gate[0] = 1'b0;
        run(1);
        held = out[0];
        for (int i = 0; i < 4; i++) begin
            step();
            chk("hold_frozen", 32'(out[0]), 32'(held));
        end
        gate[0] = 1'b1;
        run(10);

        // Boundary divisors: n=2 and n=255
        write(1, 1, 2);
        write(2, 4, 255);
        run(280);

        // Reset mid-count, then STOP on a running channel
        async_reset();
        write(0, 1, 3);
        run(4);
        write(0, 7, 0);
        chk("stop_active", 32'(active[0]), 32'd0);
        chk("stop_out", 32'(out[0]), 32'd0);
        run(2);

        // Random writes and gating
        for (int i = 0; i < 800; i++) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_ch   = 2'($urandom_range(0, 3));
            wr_mode = 3'($urandom_range(0, 7));
            wr_cnt  = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(250, 255))
                                                   : CW'($urandom_range(0, 12));
            for (int c = 0; c < NCH; c++) gate[c] = ($urandom_range(0, 7) != 0);
            step();
            if (i == 400) async_reset();
        end
        wr_en = 1'b0;
        run(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
